// File: rtl/ram_pixel_loader.sv
// ram_pixel_loader: streams one picture_size^2 frame of pixels into the neuroset pixel RAM port.
// Define LOADER_INVERT_EN to invert pixel polarity before conversion.
module ram_pixel_loader #(
  parameter int picture_size = 28,
  parameter int SIZE_1 = 11,
  parameter int SIZE_address_pix = 13,
  parameter int PIX_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SIZE_address_pix-1:0] base_addr,
  input  logic                        s_valid,
  input  logic [PIX_W-1:0]            s_data,
  output logic                        s_ready,
  output logic                        we_p,
  output logic [SIZE_address_pix-1:0] write_addressp,
  output logic [SIZE_1-1:0]           dp,
  output logic                        busy,
  output logic                        done,
  output logic [SIZE_address_pix-1:0] pix_count
);
  localparam int N = picture_size * picture_size;
  localparam int SH = SIZE_1 - 1 - PIX_W;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  state_t state, state_nx;
  logic [SIZE_address_pix-1:0] base;
  logic [PIX_W-1:0] px;
  logic accept, last;
`ifdef LOADER_INVERT_EN
  assign px = ~s_data;
`else
  assign px = s_data;
`endif
  assign s_ready = state == LOAD;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign accept = s_ready && s_valid;
  assign last = pix_count == SIZE_address_pix'(N - 1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? LOAD : IDLE;
      LOAD:    state_nx = (accept && last) ? FLUSH : LOAD;
      FLUSH:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  // MSB stays clear so the stored word is always a non-negative fixed-point value
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      we_p <= 1'b0;
      write_addressp <= '0;
      dp <= '0;
      pix_count <= '0;
      base <= '0;
    end else begin
      state <= state_nx;
      we_p <= accept;
      if (state == IDLE && start) begin
        base <= base_addr;
        pix_count <= '0;
      end
      if (accept) begin
        write_addressp <= base + pix_count;
        dp <= SIZE_1'(px) << SH;
        pix_count <= pix_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ram_pixel_loader.sv
// tb_ram_pixel_loader: scoreboard bench for ram_pixel_loader (2x2 and 28x28 instances sharing the stream).
module tb_ram_pixel_loader;
  localparam int AW = 13, DW = 11, PW = 8, N0 = 4, N1 = 784;
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, sel = 1'b0;
  logic [1:0] start = '0, s_ready, we_p, busy, done;
  logic [1:0] pwe = '0;
  logic [AW-1:0] base_addr = '0, base = '0;
  logic [PW-1:0] s_data = '0;
  logic [AW-1:0] addr [2];
  logic [AW-1:0] cnt [2];
  logic [DW-1:0] dp [2];
  logic [AW+DW-1:0] q0 [$];
  logic [AW+DW-1:0] q1 [$];
  logic [AW+DW-1:0] e0, e1;
  logic [PW-1:0] pix [$];
  int errors = 0, checks = 0, n = 0;
  int ndone [2] = '{0, 0};

  always #5 clk = ~clk;

  ram_pixel_loader #(.picture_size(2)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .base_addr(base_addr), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready[0]), .we_p(we_p[0]), .write_addressp(addr[0]), .dp(dp[0]), .busy(busy[0]),
    .done(done[0]), .pix_count(cnt[0]));

  ram_pixel_loader #(.picture_size(28)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .base_addr(base_addr), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready[1]), .we_p(we_p[1]), .write_addressp(addr[1]), .dp(dp[1]), .busy(busy[1]),
    .done(done[1]), .pix_count(cnt[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] conv(input logic [PW-1:0] d);
`ifdef LOADER_INVERT_EN
    d = ~d;
`endif
    return DW'(d) << (DW - 1 - PW);
  endfunction

  always @(negedge clk) if (!rst) begin
    if (we_p[0]) begin
      if (q0.size() == 0) check("unexpected_we0", 32'(1), 32'(0));
      else begin
        e0 = q0.pop_front();
        check("addr0", 32'(addr[0]), 32'(e0[AW+DW-1:DW]));
        check("dp0", 32'(dp[0]), 32'(e0[DW-1:0]));
      end
    end
    if (we_p[1]) begin
      if (q1.size() == 0) check("unexpected_we1", 32'(1), 32'(0));
      else begin
        e1 = q1.pop_front();
        check("addr1", 32'(addr[1]), 32'(e1[AW+DW-1:DW]));
        check("dp1", 32'(dp[1]), 32'(e1[DW-1:0]));
      end
    end
    for (int i = 0; i < 2; i++) if (done[i]) begin
      check("done_after_we", 32'(pwe[i]), 32'(1));
      ndone[i]++;
    end
    pwe <= we_p;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input bit s);
    check("z_ready", 32'(s_ready[s]), 32'(0));
    check("z_we", 32'(we_p[s]), 32'(0));
    check("z_busy", 32'(busy[s]), 32'(0));
    check("z_done", 32'(done[s]), 32'(0));
    check("z_addr", 32'(addr[s]), 32'(0));
    check("z_dp", 32'(dp[s]), 32'(0));
    check("z_cnt", 32'(cnt[s]), 32'(0));
  endtask

  task automatic do_start(input bit s, input logic [AW-1:0] b);
    step;
    sel = s;
    base = b;
    base_addr = b;
    start[s] = 1'b1;
    n = 0;
    step;
    start[s] = 1'b0;
    base_addr = b ^ 13'h0155;
    check("ld_busy", 32'(busy[s]), 32'(1));
    check("ld_ready", 32'(s_ready[s]), 32'(1));
    check("ld_cnt", 32'(cnt[s]), 32'(0));
  endtask

  task automatic feed(input int lim, input bit rnd, input int sp);
    int cyc = 0;
    while (n < lim && cyc < 20000) begin
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data = pix.size() > 0 ? pix[0] : PW'($urandom);
      start[sel] = cyc == sp;
      if (s_valid && s_ready[sel]) begin
        if (pix.size() > 0) void'(pix.pop_front());
        if (sel) q1.push_back({AW'(32'(base) + n), conv(s_data)});
        else q0.push_back({AW'(32'(base) + n), conv(s_data)});
        n++;
      end
      step;
      cyc++;
    end
    s_valid = 1'b0;
    start[sel] = 1'b0;
    check("feed_timeout", 32'(cyc < 20000), 32'(1));
  endtask

  task automatic finish_frame(input bit s, input int nn);
    int d = ndone[s];
    check("rdy_after_last", 32'(s_ready[s]), 32'(0));
    check("flush_we", 32'(we_p[s]), 32'(1));
    check("flush_busy", 32'(busy[s]), 32'(1));
    check("cnt_final", 32'(cnt[s]), 32'(nn));
    step;
    check("done_high", 32'(done[s]), 32'(1));
    check("done_we", 32'(we_p[s]), 32'(0));
    step;
    check("done_pulse", 32'(done[s]), 32'(0));
    check("idle_busy", 32'(busy[s]), 32'(0));
    check("done_count", 32'(ndone[s]), 32'(d + 1));
    check("q_empty", 32'(s ? q1.size() : q0.size()), 32'(0));
  endtask

  initial begin
    int d;
    repeat (3) step;
    chk_zero(0);
    chk_zero(1);
    rst = 1'b0;
    s_valid = 1'b1;
    repeat (4) begin
      step;
      check("idle_we", 32'(we_p), 32'(0));
      check("idle_ready", 32'(s_ready), 32'(0));
    end
    s_valid = 1'b0;
    pix = '{8'd0, 8'd1, 8'd128, 8'd255};
    do_start(0, 13'd100);
    feed(N0, 1'b0, -1);
    finish_frame(0, N0);
`ifdef LOADER_INVERT_EN
    check("last_dp", 32'(dp[0]), 32'(0));
`else
    check("last_dp", 32'(dp[0]), 32'(1020));
`endif
    check("last_addr", 32'(addr[0]), 32'(103));
    do_start(0, 13'd8190);
    feed(N0, 1'b1, -1);
    finish_frame(0, N0);
    check("wrap_last_addr", 32'(addr[0]), 32'(1));
    do_start(1, 13'd300);
    feed(N1, 1'b1, 7);
    finish_frame(1, N1);
    check("bp_last_addr", 32'(addr[1]), 32'(1083));
    d = ndone[1];
    do_start(1, 13'd4000);
    feed(10, 1'b1, -1);
    rst = 1'b1;
    step;
    chk_zero(1);
    check("no_partial_done", 32'(ndone[1]), 32'(d));
    q1.delete();
    rst = 1'b0;
    do_start(1, 13'd5000);
    feed(N1, 1'b0, -1);
    finish_frame(1, N1);
    check("post_rst_last_addr", 32'(addr[1]), 32'(5783));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_pixel_loader.md
Name: ram_pixel_loader

Overview:
- Upstream feeder for the pixel memory port of the neuroset RAM block.
- Accepts a byte-wide pixel stream from the image source over a valid/ready handshake.
- Converts each pixel to a signed SIZE_1 fixed-point value and writes one full picture (picture_size*picture_size words) into the RAM, starting at a programmable base address.
- Drives the RAM's we_p, write_addressp and dp inputs directly and signals completion to the network controller.

Parameters:
- picture_size, 28, picture edge length; frame length N = picture_size*picture_size.
- SIZE_1, 11, width of a stored pixel word; must be >= 9.
- SIZE_address_pix, 13, pixel address width.
- PIX_W, 8, width of an incoming unsigned pixel.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to load one frame; sampled only in IDLE.
- base_addr  in  SIZE_address_pix  first RAM address of the frame; latched on an accepted start.
- s_valid  in  1  upstream pixel valid.
- s_data  in  PIX_W  upstream pixel, unsigned.
- s_ready  out  1  loader can accept a pixel.
- we_p  out  1  RAM pixel write enable.
- write_addressp  out  SIZE_address_pix  RAM pixel write address.
- dp  out  SIZE_1  signed RAM pixel write data.
- busy  out  1  frame load in progress.
- done  out  1  one-cycle pulse: frame fully written.
- pix_count  out  SIZE_address_pix  pixels accepted in the current frame.

Behaviour:
- Reset: the FSM goes to IDLE. s_ready, we_p, busy and done are 0. write_addressp, dp and pix_count are 0. Any pending write is dropped.
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - s_ready=0, busy=0.
  - start=1 latches base_addr, clears pix_count, and moves to LOAD on the next cycle.
  - s_valid in IDLE is ignored; no write occurs.
- LOAD:
  - s_ready=1, busy=1.
  - A beat is accepted when s_valid & s_ready. The accepted beat at cycle t gives, at cycle t+1: we_p=1, write_addressp=(base+pix_count_old) mod 2^SIZE_address_pix, and dp=converted pixel. pix_count increments at t+1.
  - No accept gives we_p=0 next cycle; write_addressp and dp hold their values.
  - When the accepted beat is the N-th, the next state is FLUSH. s_ready is 0 from t+1 onward, so the upstream never sees an extra accept.
- FLUSH: the last write is on the bus (we_p=1) and busy=1. Next state is DONE.
- DONE: done=1 for exactly one cycle, we_p=0, busy=1. Next state is IDLE.
- start outside IDLE is ignored. A new frame requires start again in IDLE, at the earliest the cycle after DONE.
- Conversion: dp = zero-extended s_data shifted left by (SIZE_1-1-PIX_W). Result is always non-negative; MSB is 0. With defaults, 255 -> 1020 (0x3FC).
- Address wrap: the base+count addition wraps modulo 2^SIZE_address_pix with no error flag.
- Reset mid-frame: the load is aborted immediately with no partial done. RAM contents already written remain.

Optional Feature:
- Macro: LOADER_INVERT_EN.
- Defined: the pixel is inverted (2^PIX_W-1-s_data) before conversion, so the camera's dark-on-light image matches the training polarity. With defaults, 0 -> 1020 and 255 -> 0.
- Undefined: no inversion; conversion exactly as above.
- Timing and handshake are identical in both builds.

Test Plan:
- Basic frame: picture_size=2, base_addr=100, continuous s_valid, pixels 0, 1, 128, 255 -> writes (100,0), (101,4), (102,512), (103,1020) on consecutive cycles. done pulses once, the cycle after the last we_p. pix_count=4.
- Backpressure/gaps: picture_size=28, s_valid toggled 1-0-1 randomly -> exactly 784 writes at addresses base..base+783 in order. No duplicate or missing address. s_ready is 0 after the 784th accept.
- Wrap: base_addr=8190, picture_size=2 -> write addresses 8190, 8191, 0, 1.
- Ignored start/valid: s_valid=1 in IDLE with start=0 -> no we_p. A start pulse during LOAD -> base is not re-latched and the count continues.
- Reset mid-frame: rst asserted after 10 accepts -> next cycle all outputs are 0, no done, and a following start loads a full frame correctly.
- LOADER_INVERT_EN build: pixels 0 and 255 -> dp 1020 and 0.
